// File: rtl/y86_seq_exec_core_if.sv
`timescale 1ns/1ps
// y86_seq_exec_core_if
// Bundles the fetch/memory-side inputs and the core's result outputs of the
// sequential Y86-64 execute core.
//   icode, ifun, rA, rB : decoded instruction fields from fetch
//   valC, valP          : constant word / next sequential PC from fetch
//   valM                : word read from data memory
//   valA, valB, valE    : register-file read values and ALU result
//   CC                  : registered condition codes {ZF, SF, OF}
//   Cnd                 : condition result for cmovXX / jXX
//   PC                  : registered program counter
//   halted              : sticky stop flag
// master = fetch/memory side, slave = the core.
interface y86_seq_exec_core_if;
    logic        [3:0]  icode;
    logic        [3:0]  ifun;
    logic        [3:0]  rA;
    logic        [3:0]  rB;
    logic        [63:0] valC;
    logic        [63:0] valP;
    logic        [63:0] valM;
    logic signed [63:0] valA;
    logic signed [63:0] valB;
    logic signed [63:0] valE;
    logic        [2:0]  CC;
    logic               Cnd;
    logic        [63:0] PC;
    logic               halted;

    modport master (
        output icode, ifun, rA, rB, valC, valP, valM,
        input  valA, valB, valE, CC, Cnd, PC, halted
    );

    modport slave (
        input  icode, ifun, rA, rB, valC, valP, valM,
        output valA, valB, valE, CC, Cnd, PC, halted
    );
endinterface

// File: rtl/y86_seq_exec_core.sv
`timescale 1ns/1ps
// y86_seq_exec_core
// Sequential Y86-64 decode / execute / write-back / PC-update core. One
// instruction completes per rising clock edge; all datapath values are
// combinational from the current inputs and state.
//   clock   : single clock, state updates on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : y86_seq_exec_core_if.slave (fetch/memory inputs, results out)
// Optional feature: define IADDQ_EN to make icode C the iaddq instruction;
// otherwise icode C is invalid and halts the core.
module y86_seq_exec_core (
    input  logic                  clock,
    input  logic                  reset_n,
    y86_seq_exec_core_if.slave    bus
);

    typedef enum logic [3:0] {
        I_HALT  = 4'h0,
        I_NOP   = 4'h1,
        I_RRMOV = 4'h2,
        I_IRMOV = 4'h3,
        I_RMMOV = 4'h4,
        I_MRMOV = 4'h5,
        I_OPQ   = 4'h6,
        I_JXX   = 4'h7,
        I_CALL  = 4'h8,
        I_RET   = 4'h9,
        I_PUSH  = 4'hA,
        I_POP   = 4'hB,
        I_IADDQ = 4'hC
    } icode_e;

    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    logic [63:0] regs_q [15];
    logic [2:0]  cc_q, cc_d;
    logic [63:0] pc_q, pc_d;
    logic        halted_q;

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] val_a, val_b, val_e;
    logic        valid, cnd, of_alu, cc_we;
    logic        zf, sf, of;

    assign {zf, sf, of} = cc_q;

    // Decode: register sources
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        case (bus.icode)
            I_RRMOV, I_RMMOV, I_OPQ, I_PUSH: src_a = bus.rA;
            I_RET, I_POP:                    src_a = RSP;
            default: ;
        endcase
        case (bus.icode)
            I_RMMOV, I_MRMOV, I_OPQ:         src_b = bus.rB;
`ifdef IADDQ_EN
            I_IADDQ:                         src_b = bus.rB;
`endif
            I_CALL, I_RET, I_PUSH, I_POP:    src_b = RSP;
            default: ;
        endcase
    end

    assign val_a = (src_a == RNONE) ? '0 : regs_q[src_a];
    assign val_b = (src_b == RNONE) ? '0 : regs_q[src_b];

    // Condition evaluation from the current (registered) CC
    always_comb begin
        cnd = 1'b0;
        case (bus.ifun)
            4'h0: cnd = 1'b1;
            4'h1: cnd = (sf ^ of) | zf;
            4'h2: cnd = sf ^ of;
            4'h3: cnd = zf;
            4'h4: cnd = ~zf;
            4'h5: cnd = ~(sf ^ of);
            4'h6: cnd = ~(sf ^ of) & ~zf;
            default: cnd = 1'b0;
        endcase
    end

    // ALU and condition-code generation
    always_comb begin
        val_e  = '0;
        of_alu = 1'b0;
        cc_we  = 1'b0;
        case (bus.icode)
            I_RRMOV:          val_e = val_a;
            I_IRMOV:          val_e = bus.valC;
            I_RMMOV, I_MRMOV: val_e = val_b + bus.valC;
            I_OPQ: begin
                cc_we = 1'b1;
                case (bus.ifun)
                    4'h0: begin
                        val_e  = val_b + val_a;
                        of_alu = (val_a[63] == val_b[63]) && (val_e[63] != val_a[63]);
                    end
                    4'h1: begin
                        val_e  = val_b - val_a;
                        of_alu = (val_a[63] != val_b[63]) && (val_e[63] != val_b[63]);
                    end
                    4'h2:    val_e = val_b & val_a;
                    4'h3:    val_e = val_b ^ val_a;
                    default: val_e = '0;
                endcase
            end
`ifdef IADDQ_EN
            I_IADDQ: begin
                cc_we  = 1'b1;
                val_e  = val_b + bus.valC;
                of_alu = (val_b[63] == bus.valC[63]) && (val_e[63] != val_b[63]);
            end
`endif
            I_CALL, I_PUSH:   val_e = val_b - 64'd8;
            I_RET, I_POP:     val_e = val_b + 64'd8;
            default: ;
        endcase
        cc_d = cc_we ? {(val_e == '0), val_e[63], of_alu} : cc_q;
    end

    // Write-back destinations, validity and next PC
    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        valid = 1'b0;
        pc_d  = bus.valP;
        case (bus.icode)
            I_NOP, I_RMMOV:               valid = 1'b1;
            I_RRMOV: begin valid = 1'b1; if (cnd) dst_e = bus.rB; end
            I_IRMOV, I_OPQ: begin valid = 1'b1; dst_e = bus.rB; end
`ifdef IADDQ_EN
            I_IADDQ: begin valid = 1'b1; dst_e = bus.rB; end
`endif
            I_MRMOV: begin valid = 1'b1; dst_m = bus.rA; end
            I_JXX:   begin valid = 1'b1; if (cnd) pc_d = bus.valC; end
            I_CALL:  begin valid = 1'b1; dst_e = RSP; pc_d = bus.valC; end
            I_RET:   begin valid = 1'b1; dst_e = RSP; pc_d = bus.valM; end
            I_PUSH:  begin valid = 1'b1; dst_e = RSP; end
            I_POP:   begin valid = 1'b1; dst_e = RSP; dst_m = bus.rA; end
            default: valid = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 15; i++) regs_q[i] <= '0;
            pc_q     <= '0;
            cc_q     <= 3'b100;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (!valid) begin
                halted_q <= 1'b1;
            end else begin
                if (dst_e != RNONE) regs_q[dst_e] <= val_e;
                // Issued after the dstE write so valM wins when both target the same register.
                if (dst_m != RNONE) regs_q[dst_m] <= bus.valM;
                cc_q <= cc_d;
                pc_q <= pc_d;
            end
        end
    end

    assign bus.valA   = val_a;
    assign bus.valB   = val_b;
    assign bus.valE   = val_e;
    assign bus.Cnd    = cnd;
    assign bus.CC     = cc_q;
    assign bus.PC     = pc_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_y86_seq_exec_core.sv
`timescale 1ns/1ps
// Self-checking bench for y86_seq_exec_core: directed program fragments
// followed by randomized instructions, compared with an instruction-level
// reference model of the Y86-64 semantics.
module tb_y86_seq_exec_core;

    logic clock = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    y86_seq_exec_core_if bus ();

    y86_seq_exec_core dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Reference architectural state
    logic [63:0] m_reg [15];
    logic [2:0]  m_cc;
    logic [63:0] m_pc;
    logic        m_halt;
    // Expected combinational outputs for the instruction currently applied
    logic [63:0] e_a, e_b, e_e;
    logic        e_cnd, e_chk_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [3:0] r);
        return (r == 4'hF) ? 64'd0 : m_reg[r];
    endfunction

    function automatic logic cond(input logic [3:0] f);
        logic zf, sf, of;
        {zf, sf, of} = m_cc;
        case (f)
            4'h0: return 1'b1;
            4'h1: return (sf != of) || zf;
            4'h2: return sf != of;
            4'h3: return zf;
            4'h4: return !zf;
            4'h5: return sf == of;
            4'h6: return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
        m_cc   = 3'b100;
        m_pc   = 64'd0;
        m_halt = 1'b0;
    endtask

    // Executes one instruction on the model; overflow uses 65-bit signed arithmetic.
    task automatic model(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] c, input logic [63:0] p,
                         input logic [63:0] m);
        logic [63:0] nreg [15];
        logic [2:0]  ncc;
        logic [63:0] npc;
        logic        ok;
        logic [64:0] w;
        nreg = m_reg; ncc = m_cc; npc = p; ok = 1'b1;
        e_a = 64'd0; e_b = 64'd0; e_e = 64'd0; e_chk_e = 1'b1;
        e_cnd = cond(f);
        case (ic)
            4'h1: e_chk_e = 1'b0;
            4'h2: begin
                e_a = rd(ra); e_e = e_a;
                if (e_cnd && rb != 4'hF) nreg[rb] = e_e;
            end
            4'h3: begin e_e = c; if (rb != 4'hF) nreg[rb] = c; end
            4'h4: begin e_a = rd(ra); e_b = rd(rb); e_e = e_b + c; end
            4'h5: begin e_b = rd(rb); e_e = e_b + c; if (ra != 4'hF) nreg[ra] = m; end
            4'h6: begin
                e_a = rd(ra); e_b = rd(rb);
                case (f)
                    4'h0: begin w = {e_b[63], e_b} + {e_a[63], e_a}; e_e = w[63:0]; ncc[0] = w[64] ^ w[63]; end
                    4'h1: begin w = {e_b[63], e_b} - {e_a[63], e_a}; e_e = w[63:0]; ncc[0] = w[64] ^ w[63]; end
                    4'h2: begin e_e = e_b & e_a; ncc[0] = 1'b0; end
                    default: begin e_e = e_b ^ e_a; ncc[0] = 1'b0; end
                endcase
                ncc[2] = (e_e == 64'd0);
                ncc[1] = e_e[63];
                if (rb != 4'hF) nreg[rb] = e_e;
            end
            4'h7: begin e_chk_e = 1'b0; if (e_cnd) npc = c; end
            4'h8: begin e_b = rd(4'h4); e_e = e_b - 64'd8; nreg[4] = e_e; npc = c; end
            4'h9: begin e_a = rd(4'h4); e_b = e_a; e_e = e_b + 64'd8; nreg[4] = e_e; npc = m; end
            4'hA: begin e_a = rd(ra); e_b = rd(4'h4); e_e = e_b - 64'd8; nreg[4] = e_e; end
            4'hB: begin
                e_a = rd(4'h4); e_b = e_a; e_e = e_b + 64'd8; nreg[4] = e_e;
                if (ra != 4'hF) nreg[ra] = m;
            end
`ifdef IADDQ_EN
            4'hC: begin
                e_b = rd(rb);
                w = {e_b[63], e_b} + {c[63], c}; e_e = w[63:0];
                ncc = {(e_e == 64'd0), e_e[63], w[64] ^ w[63]};
                if (rb != 4'hF) nreg[rb] = e_e;
            end
`endif
            default: begin ok = 1'b0; e_chk_e = 1'b0; end
        endcase
        if (!m_halt) begin
            if (ok) begin m_reg = nreg; m_cc = ncc; m_pc = npc; end
            else m_halt = 1'b1;
        end
    endtask

    // Called in the clock-low phase; reads every register through the valA port.
    task automatic probe_all();
        for (int i = 0; i < 15; i++) begin
            bus.icode = 4'h6; bus.ifun = 4'h0; bus.rA = 4'(i); bus.rB = 4'hF;
            #0.2;
            chk($sformatf("reg%0d", i), bus.valA, m_reg[i]);
        end
    endtask

    task automatic chk_reg(input int r, input logic [63:0] exp);
        bus.icode = 4'h6; bus.ifun = 4'h0; bus.rA = 4'(r); bus.rB = 4'hF;
        #0.2;
        chk($sformatf("reg%0d_const", r), bus.valA, exp);
    endtask

    // Called in the clock-low phase; returns at the following falling edge.
    task automatic step(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] c, input logic [63:0] p,
                        input logic [63:0] m);
        bus.icode = ic; bus.ifun = f; bus.rA = ra; bus.rB = rb;
        bus.valC = c; bus.valP = p; bus.valM = m;
        model(ic, f, ra, rb, c, p, m);
        #0.5;
        chk($sformatf("valA_ic%h", ic), bus.valA, e_a);
        chk($sformatf("valB_ic%h", ic), bus.valB, e_b);
        if (e_chk_e) chk($sformatf("valE_ic%h", ic), bus.valE, e_e);
        chk($sformatf("Cnd_ic%h_f%h", ic, f), {63'd0, bus.Cnd}, {63'd0, e_cnd});
        @(posedge clock);
        #1;
        chk("PC", bus.PC, m_pc);
        chk("CC", {61'd0, bus.CC}, {61'd0, m_cc});
        chk("halted", {63'd0, bus.halted}, {63'd0, m_halt});
        @(negedge clock);
    endtask

    // Asynchronous reset asserted mid-cycle; returns at a falling edge after release.
    task automatic reset_mid();
        #1;
        reset_n = 1'b0;
        m_reset();
        #0.3;
        chk("rst_PC", bus.PC, 64'd0);
        chk("rst_halted", {63'd0, bus.halted}, 64'd0);
        chk("rst_CC", {61'd0, bus.CC}, 64'd4);
        probe_all();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return '1;
            4: return 64'($urandom_range(0, 32));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0] ic, f, ra, rb;
        int halt_steps;

        reset_n = 1'b0;
        bus.icode = 4'h1; bus.ifun = 4'h0; bus.rA = 4'hF; bus.rB = 4'hF;
        bus.valC = '0; bus.valP = '0; bus.valM = '0;
        m_reset();
        @(negedge clock);
        chk("reset_PC", bus.PC, 64'd0);
        chk("reset_CC", {61'd0, bus.CC}, 64'd4);
        chk("reset_halted", {63'd0, bus.halted}, 64'd0);
        probe_all();
        @(negedge clock);
        reset_n = 1'b1;

        // irmovq $10,%rax
        step(4'h3, 4'h0, 4'hF, 4'h0, 64'd10, 64'd10, 64'd0);
        chk("irmov_PC", bus.PC, 64'd10);
        chk("irmov_CC", {61'd0, bus.CC}, 64'd4);
        chk_reg(0, 64'd10);

        // rbx=3; subq %rax,%rbx; jl 0x40
        step(4'h3, 4'h0, 4'hF, 4'h3, 64'd3, 64'd20, 64'd0);
        step(4'h6, 4'h1, 4'h0, 4'h3, 64'd0, 64'd22, 64'd0);
        chk("sub_CC", {61'd0, bus.CC}, 64'd2);
        chk_reg(3, 64'hFFFF_FFFF_FFFF_FFF9);
        step(4'h7, 4'h2, 4'hF, 4'hF, 64'h40, 64'd31, 64'd0);
        chk("jl_PC", bus.PC, 64'h40);

        // signed overflow on addq
        step(4'h3, 4'h0, 4'hF, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h4a, 64'd0);
        step(4'h3, 4'h0, 4'hF, 4'h3, 64'd1, 64'h54, 64'd0);
        step(4'h6, 4'h0, 4'h0, 4'h3, 64'd0, 64'h56, 64'd0);
        chk("add_ovf_CC", {61'd0, bus.CC}, 64'd3);
        chk_reg(3, 64'h8000_0000_0000_0000);

        // stack: pushq, call, ret
        step(4'h3, 4'h0, 4'hF, 4'h4, 64'h100, 64'h60, 64'd0);
        step(4'hA, 4'h0, 4'h0, 4'hF, 64'd0, 64'h62, 64'd0);
        chk_reg(4, 64'hF8);
        step(4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h6b, 64'd0);
        chk("call_PC", bus.PC, 64'h200);
        chk_reg(4, 64'hF0);
        step(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'h201, 64'h13);
        chk("ret_PC", bus.PC, 64'h13);
        chk_reg(4, 64'hF8);

        // popq %rsp takes valM; xorq sets ZF; cmovne must not write
        step(4'hB, 4'h0, 4'h4, 4'hF, 64'd0, 64'h15, 64'h55);
        chk_reg(4, 64'h55);
        step(4'h6, 4'h3, 4'h0, 4'h0, 64'd0, 64'h17, 64'd0);
        step(4'h2, 4'h4, 4'h0, 4'h3, 64'd0, 64'h19, 64'd0);
        chk_reg(3, 64'h8000_0000_0000_0000);

        // halt at 0x20, then frozen, then async reset
        step(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h20, 64'd0);
        chk("nop_PC", bus.PC, 64'h20);
        step(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h21, 64'd0);
        chk("halt_flag", {63'd0, bus.halted}, 64'd1);
        chk("halt_PC", bus.PC, 64'h20);
        step(4'h3, 4'h0, 4'hF, 4'h0, 64'd99, 64'h50, 64'd0);
        chk("frozen_PC", bus.PC, 64'h20);
        chk_reg(0, 64'd0);
        step(4'h6, 4'h0, 4'h0, 4'h0, 64'd0, 64'h52, 64'd0);
        reset_mid();

        // randomized instruction stream
        halt_steps = 0;
        for (int n = 0; n < 500; n++) begin
            if (m_halt) begin
                halt_steps++;
                if (halt_steps > 2) begin
                    reset_mid();
                    halt_steps = 0;
                end
            end
            case ($urandom_range(0, 99)) inside
                [0:24]:  ic = 4'h3;
                [25:27]: ic = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'(4'hB + $urandom_range(1, 4));
                default: ic = 4'($urandom_range(1, 11));
            endcase
            f  = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            if (n % 8 == 0) probe_all();
            step(ic, f, ra, rb, rnd64(), rnd64(), rnd64());
        end
        probe_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/y86_seq_exec_core.md
# y86_seq_exec_core

Sequential Y86-64 decode/execute/write-back/PC-update core. Sits between the instruction fetch stage (supplies `icode`, `ifun`, `rA`, `rB`, `valC`, `valP`) and the data-memory stage (supplies `valM`), and returns the next PC to fetch. Holds the 15-entry register file, the condition codes and the PC register; every datapath value is combinational within one cycle.

## Interface
- No parameters; data width fixed at 64 bits.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `icode` in 4: instruction code from fetch.
- `ifun` in 4: function / condition code.
- `rA`, `rB` in 4 each: register specifiers; 4'hF = none.
- `valC` in 64: constant word.
- `valP` in 64: address of the next sequential instruction.
- `valM` in 64: word read from data memory.
- `valA`, `valB` out 64 each: register-file read values, signed.
- `valE` out 64: ALU result, signed.
- `CC` out 3: {ZF, SF, OF}, registered.
- `Cnd` out 1: condition result for cmovXX/jXX.
- `PC` out 64: registered program counter.
- `halted` out 1: sticky stop flag.

## Operation
- Opcodes: 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq. Any other code is invalid.
- Decode (combinational):
  - srcA = rA for 2/4/6/A; rsp (4) for 9/B; else none.
  - srcB = rB for 4/5/6; rsp for 8/9/A/B; else none.
  - A read of "none" returns 0.
- ALU:
  - 2: valA+0. 3: valC+0. 4/5: valB+valC.
  - 6: valB op valA, with ifun 0 add, 1 sub (valB−valA), 2 and, 3 xor.
  - 8/A: valB−8. 9/B: valB+8.
  - Arithmetic is two's complement and wraps mod 2^64.
- CC, updated only for OPq:
  - ZF = (valE==0); SF = valE[63].
  - OF for add: operands have the same sign and the result sign differs.
  - OF for sub: valA and valB signs differ and the result sign differs from valB.
  - OF = 0 for and/xor.
- Cnd from the current CC, by ifun:
  - 0: 1. 1 (le): (SF^OF)|ZF. 2 (l): SF^OF. 3 (e): ZF.
  - 4 (ne): ~ZF. 5 (ge): ~(SF^OF). 6 (g): ~(SF^OF)&~ZF. 7–F: 0.
- Write-back at the clock edge:
  - dstE = rB for 3/6 and for 2 when Cnd; rsp for 8/9/A/B.
  - dstM = rA for 5/B.
  - When dstE==dstM, valM wins (popq %rsp loads the memory value).
  - Register F is never written.
- Next PC: 8 → valC; 7 with Cnd → valC; 9 → valM; otherwise valP.
- Halt / invalid opcode:
  - That edge sets `halted` and writes no register, CC or PC.
  - While `halted`, all state is frozen until reset.

## Timing
- Outputs `valA`, `valB`, `valE` and `Cnd` are combinational from the inputs and current state, with zero-cycle latency.
- Register file, CC, PC and `halted` update together on the rising edge; one instruction per cycle.
- Results are visible to the next instruction's decode in the following cycle; no forwarding is needed.
- Reset (async, any time, including mid-cycle):
  - PC = 0, CC = 3'b100 (ZF=1), all registers 0, `halted` = 0.
  - Outputs follow the combinational paths immediately.
- Release of `reset_n` is synchronised by the caller; the first edge after release executes the instruction at PC 0.

## Configuration
- `IADDQ_EN` defined: icode C is `iaddq`.
  - srcB = rB; valE = valB+valC; CC updated with add rules; dstE = rB; next PC = valP.
- Without the macro: icode C is invalid and halts as above.

## Test plan
- Reset then `irmovq $10,%rax` (3,0,F,0,valC=10,valP=10) -> after edge rax=10, PC=10, CC unchanged 3'b100.
- rax=10, rbx=3, `subq %rax,%rbx` (6,1,0,3) -> valE=−7, rbx=−7, CC={0,1,0}; then `jl` with valC=0x40 -> Cnd=1, PC=0x40.
- rax=0x7FFF_FFFF_FFFF_FFFF, rbx=1, `addq` -> valE=0x8000_0000_0000_0000, CC={0,1,1}.
- rsp=0x100: `pushq %rax` -> valE=0xF8, rsp=0xF8; `call` valC=0x200 -> PC=0x200, rsp decremented by 8; `ret` with valM=0x13 -> PC=0x13, rsp incremented by 8.
- `popq %rsp` with valM=0x55 -> rsp=0x55; `cmovne` with ZF=1 -> Cnd=0, rB unchanged.
- icode 0 at PC=0x20 -> `halted`=1, PC stays 0x20 for subsequent edges; assert `reset_n` low mid-run -> PC=0, `halted`=0 immediately.
